// File: rtl/axi_slave_mem_if.sv
// axi_slave_mem_if: AXI4 bus bundle between the master and the memory slave
interface axi_slave_mem_if;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport slave (
        input  awaddr, awlen, awsize, awburst, awvalid,
        input  wdata, wstrb, wlast, wvalid,
        input  bready,
        input  araddr, arlen, arsize, arburst, arvalid,
        input  rready,
        output awready, wready, bresp, bvalid,
        output arready, rdata, rresp, rlast, rvalid
    );

    modport master (
        output awaddr, awlen, awsize, awburst, awvalid,
        output wdata, wstrb, wlast, wvalid,
        output bready,
        output araddr, arlen, arsize, arburst, arvalid,
        output rready,
        input  awready, wready, bresp, bvalid,
        input  arready, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/axi_slave_mem.sv
// axi_slave_mem: single-outstanding AXI4 slave backed by a word-addressed memory
module axi_slave_mem #(
    parameter int DEPTH  = 256,
    parameter int DATA_W = 32
) (
    input  logic           aclk,
    input  logic           areset_n,
    axi_slave_mem_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    typedef enum logic [1:0] {IDLE, WDATA, WRESP, RDATA} state_t;

    state_t            state, state_nx;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     idx;
    logic [7:0]        len, cnt;
    logic [1:0]        burst, resp;
    logic [31:0]       a_addr;
    logic [7:0]        a_len;
    logic [2:0]        a_size;
    logic [1:0]        a_burst, a_resp;
    logic [AW-1:0]     a_idx;
    logic              w_hs, r_hs, last_beat, unused;

    assign a_addr    = bus.awvalid ? bus.awaddr  : bus.araddr;
    assign a_len     = bus.awvalid ? bus.awlen   : bus.arlen;
    assign a_size    = bus.awvalid ? bus.awsize  : bus.arsize;
    assign a_burst   = bus.awvalid ? bus.awburst : bus.arburst;
    assign a_idx     = a_addr[AW+1:2];
    assign a_resp    = (a_size != 3'd2 || a_burst[1]) ? SLVERR :
                       (a_burst == 2'b01 && 32'(a_idx) + 32'(a_len) >= 32'(DEPTH)) ? DECERR : OKAY;
    assign w_hs      = bus.wvalid && bus.wready;
    assign r_hs      = bus.rvalid && bus.rready;
    assign last_beat = cnt == len;
    assign unused    = ^{a_addr[31:AW+2], a_addr[1:0]};

    // next state and handshake outputs; everything forced low while in reset
    always_comb begin
        state_nx    = state;
        bus.awready = 1'b0;
        bus.arready = 1'b0;
        bus.wready  = 1'b0;
        bus.bvalid  = 1'b0;
        bus.bresp   = OKAY;
        bus.rvalid  = 1'b0;
        bus.rlast   = 1'b0;
        bus.rresp   = OKAY;
        bus.rdata   = '0;
        if (areset_n) begin
            case (state)
                IDLE: begin
                    bus.awready = 1'b1;
                    bus.arready = !bus.awvalid;
                    state_nx    = bus.awvalid ? WDATA : bus.arvalid ? RDATA : IDLE;
                end
                WDATA: begin
                    bus.wready = 1'b1;
                    state_nx   = (bus.wvalid && last_beat) ? WRESP : WDATA;
                end
                WRESP: begin
                    bus.bvalid = 1'b1;
                    bus.bresp  = resp;
                    state_nx   = bus.bready ? IDLE : WRESP;
                end
                RDATA: begin
                    bus.rvalid = 1'b1;
                    bus.rresp  = resp;
                    bus.rlast  = last_beat;
                    bus.rdata  = (resp == OKAY) ? mem[idx] : '0;
                    state_nx   = (bus.rready && last_beat) ? IDLE : RDATA;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // state register, burst context capture, beat stepping and sticky wlast error
    always_ff @(posedge aclk) begin
        if (!areset_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && (bus.awvalid || bus.arvalid)) begin
                idx   <= a_idx;
                len   <= a_len;
                burst <= a_burst;
                resp  <= a_resp;
                cnt   <= '0;
            end
            if (w_hs || r_hs) begin
                cnt <= cnt + 8'd1;
                idx <= (burst == 2'b01) ? idx + 1'b1 : idx;
            end
            if (w_hs && bus.wlast != last_beat && resp == OKAY)
                resp <= SLVERR;
        end
    end

    // byte-lane writes for bursts that were accepted as OKAY; contents survive reset
    always_ff @(posedge aclk) begin
        if (w_hs && resp == OKAY)
            for (int b = 0; b < 4; b++)
                if (bus.wstrb[b])
                    mem[idx][8*b +: 8] <= bus.wdata[8*b +: 8];
    end
endmodule

// File: tb/tb_axi_slave_mem.sv
// tb_axi_slave_mem: directed checks of the AXI memory slave
module tb_axi_slave_mem;
    logic aclk = 1'b0;
    logic areset_n = 1'b0;
    int   vecs = 0;
    int   errs = 0;

    axi_slave_mem_if bus();

    axi_slave_mem #(.DEPTH(256), .DATA_W(32)) dut (
        .aclk    (aclk),
        .areset_n(areset_n),
        .bus     (bus)
    );

    always #5 aclk = ~aclk;

    task automatic tick;
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic aw(input logic [31:0] a, input logic [7:0] l, input logic [1:0] b, input logic [2:0] s = 3'd2);
        bus.awaddr = a; bus.awlen = l; bus.awburst = b; bus.awsize = s; bus.awvalid = 1'b1;
        #1;
        chk("awready", 32'(bus.awready), 32'd1);
        tick;
        bus.awvalid = 1'b0;
    endtask

    task automatic ar(input logic [31:0] a, input logic [7:0] l, input logic [1:0] b = 2'b01);
        bus.araddr = a; bus.arlen = l; bus.arburst = b; bus.arsize = 3'd2; bus.arvalid = 1'b1;
        #1;
        chk("arready", 32'(bus.arready), 32'd1);
        tick;
        bus.arvalid = 1'b0;
    endtask

    task automatic w(input logic [31:0] d, input logic [3:0] s, input logic l);
        bus.wdata = d; bus.wstrb = s; bus.wlast = l; bus.wvalid = 1'b1;
        #1;
        chk("wready", 32'(bus.wready), 32'd1);
        tick;
        bus.wvalid = 1'b0;
    endtask

    task automatic b(input logic [1:0] exp);
        chk("bvalid", 32'(bus.bvalid), 32'd1);
        chk("bresp", 32'(bus.bresp), 32'(exp));
        bus.bready = 1'b1;
        tick;
        bus.bready = 1'b0;
    endtask

    task automatic r(input logic [31:0] d, input logic l, input logic [1:0] rs);
        bus.rready = 1'b1;
        #1;
        chk("rvalid", 32'(bus.rvalid), 32'd1);
        chk("rdata", bus.rdata, d);
        chk("rlast", 32'(bus.rlast), 32'(l));
        chk("rresp", 32'(bus.rresp), 32'(rs));
        tick;
        bus.rready = 1'b0;
    endtask

    task automatic wr1(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s = 4'hF);
        aw(a, 8'd0, 2'b01);
        w(d, s, 1'b1);
        b(2'b00);
    endtask

    task automatic rd1(input logic [31:0] a, input logic [31:0] d);
        ar(a, 8'd0);
        r(d, 1'b1, 2'b00);
    endtask

    task automatic idle_outs(input string tag);
        chk({tag, " awready"}, 32'(bus.awready), 32'd0);
        chk({tag, " arready"}, 32'(bus.arready), 32'd0);
        chk({tag, " wready"}, 32'(bus.wready), 32'd0);
        chk({tag, " bvalid"}, 32'(bus.bvalid), 32'd0);
        chk({tag, " rvalid"}, 32'(bus.rvalid), 32'd0);
        chk({tag, " rlast"}, 32'(bus.rlast), 32'd0);
        chk({tag, " bresp"}, 32'(bus.bresp), 32'd0);
        chk({tag, " rresp"}, 32'(bus.rresp), 32'd0);
        chk({tag, " rdata"}, bus.rdata, 32'd0);
    endtask

    initial begin
        bus.awaddr = '0; bus.awlen = '0; bus.awsize = 3'd2; bus.awburst = 2'b01; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
        bus.araddr = '0; bus.arlen = '0; bus.arsize = 3'd2; bus.arburst = 2'b01; bus.arvalid = 1'b0;
        bus.rready = 1'b0;
        tick;
        tick;
        idle_outs("reset");
        areset_n = 1'b1;
        #1;
        chk("post-reset awready", 32'(bus.awready), 32'd1);
        chk("post-reset arready", 32'(bus.arready), 32'd1);

        aw(32'h4, 8'd3, 2'b01);
        w(32'hDEADBEEF, 4'hF, 1'b0);
        w(32'hDEADBEF0, 4'hF, 1'b0);
        w(32'hDEADBEF1, 4'hF, 1'b0);
        w(32'hDEADBEF2, 4'hF, 1'b1);
        b(2'b00);
        ar(32'h4, 8'd3);
        r(32'hDEADBEEF, 1'b0, 2'b00);
        r(32'hDEADBEF0, 1'b0, 2'b00);
        r(32'hDEADBEF1, 1'b0, 2'b00);
        r(32'hDEADBEF2, 1'b1, 2'b00);
        chk("read done rvalid", 32'(bus.rvalid), 32'd0);

        ar(32'h4, 8'd3);
        r(32'hDEADBEEF, 1'b0, 2'b00);
        r(32'hDEADBEF0, 1'b0, 2'b00);
        for (int i = 0; i < 3; i++) begin
            chk("stall rvalid", 32'(bus.rvalid), 32'd1);
            chk("stall rdata", bus.rdata, 32'hDEADBEF1);
            chk("stall rlast", 32'(bus.rlast), 32'd0);
            tick;
        end
        r(32'hDEADBEF1, 1'b0, 2'b00);
        r(32'hDEADBEF2, 1'b1, 2'b00);
        chk("stall read done rvalid", 32'(bus.rvalid), 32'd0);

        aw(32'h30, 8'd0, 2'b01);
        w(32'h30303030, 4'hF, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk("bstall bvalid", 32'(bus.bvalid), 32'd1);
            chk("bstall bresp", 32'(bus.bresp), 32'd0);
            tick;
        end
        b(2'b00);
        chk("bstall done bvalid", 32'(bus.bvalid), 32'd0);
        rd1(32'h30, 32'h30303030);

        wr1(32'h10, 32'hAABBCCDD);
        wr1(32'h10, 32'h11223344, 4'b0101);
        rd1(32'h10, 32'hAA22CC44);

        bus.awaddr = 32'h20; bus.awlen = 8'd0; bus.awburst = 2'b01; bus.awsize = 3'd2; bus.awvalid = 1'b1;
        bus.araddr = 32'h4;  bus.arlen = 8'd0; bus.arburst = 2'b01; bus.arsize = 3'd2; bus.arvalid = 1'b1;
        #1;
        chk("both awready", 32'(bus.awready), 32'd1);
        chk("both arready", 32'(bus.arready), 32'd0);
        tick;
        bus.awvalid = 1'b0;
        #1;
        chk("wdata arready", 32'(bus.arready), 32'd0);
        w(32'h12345678, 4'hF, 1'b1);
        chk("wresp arready", 32'(bus.arready), 32'd0);
        b(2'b00);
        chk("after b arready", 32'(bus.arready), 32'd1);
        tick;
        bus.arvalid = 1'b0;
        r(32'hDEADBEEF, 1'b1, 2'b00);
        rd1(32'h20, 32'h12345678);

        aw(32'h4, 8'd0, 2'b10);
        w(32'hFFFFFFFF, 4'hF, 1'b1);
        b(2'b10);
        rd1(32'h4, 32'hDEADBEEF);

        aw(32'h4, 8'd0, 2'b01, 3'd1);
        w(32'hFFFFFFFF, 4'hF, 1'b1);
        b(2'b10);
        rd1(32'h4, 32'hDEADBEEF);

        ar(32'h3FC, 8'd1);
        r(32'h0, 1'b0, 2'b11);
        r(32'h0, 1'b1, 2'b11);
        chk("decerr done rvalid", 32'(bus.rvalid), 32'd0);

        aw(32'h40, 8'd3, 2'b01);
        w(32'h40404040, 4'hF, 1'b0);
        w(32'h41414141, 4'hF, 1'b1);
        w(32'h42424242, 4'hF, 1'b0);
        w(32'h43434343, 4'hF, 1'b1);
        b(2'b10);

        aw(32'h80, 8'd3, 2'b01);
        for (int i = 0; i < 4; i++) w(32'h0, 4'hF, i == 3);
        b(2'b00);
        aw(32'h80, 8'd3, 2'b01);
        w(32'hA1A1A1A1, 4'hF, 1'b0);
        w(32'hA2A2A2A2, 4'hF, 1'b0);
        areset_n = 1'b0;
        #1;
        idle_outs("mid-burst reset");
        tick;
        idle_outs("reset edge");
        areset_n = 1'b1;
        #1;
        chk("reset idle awready", 32'(bus.awready), 32'd1);
        chk("reset idle wready", 32'(bus.wready), 32'd0);
        ar(32'h80, 8'd3);
        r(32'hA1A1A1A1, 1'b0, 2'b00);
        r(32'hA2A2A2A2, 1'b0, 2'b00);
        r(32'h0, 1'b0, 2'b00);
        r(32'h0, 1'b1, 2'b00);
        wr1(32'h88, 32'hC0FFEE00);
        rd1(32'h88, 32'hC0FFEE00);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
